// File: rtl/rv32i_mem_pkg.sv
// rtl/rv32i_mem_pkg.sv - shared types and constants for the RV32I data-memory responder
package rv32i_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [3:0] STRB_B0 = 4'b0001;
   localparam logic [3:0] STRB_B1 = 4'b0010;
   localparam logic [3:0] STRB_B2 = 4'b0100;
   localparam logic [3:0] STRB_B3 = 4'b1000;
   localparam logic [3:0] STRB_H0 = 4'b0011;
   localparam logic [3:0] STRB_H1 = 4'b1100;
   localparam logic [3:0] STRB_W  = 4'b1111;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 4;

   // Only naturally aligned byte, halfword and word stores are legal
   function automatic logic strb_legal(input logic [3:0] strb);
      logic ok;
      case (strb)
         STRB_B0, STRB_B1, STRB_B2, STRB_B3,
         STRB_H0, STRB_H1, STRB_W: ok = 1'b1;
         default:                  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// rtl/byte_lane_ram.sv - word-organised RAM with per-lane write enables and a registered read port
module byte_lane_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [3:0]            we,
   input  logic [31:0]           wdata,
   input  logic                  re,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Write-first per lane, so a simultaneous store and read returns the merged word
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         for (int i = 0; i < 4; i++) begin
            rdata_d[8*i +: 8] = we[i] ? wdata[8*i +: 8] : mem[addr][8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= 32'h0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with fixed access latency
module data_mem_responder
   import rv32i_mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Req_Valid,
   output logic        Req_Ready,
   input  logic        Req_Write,
   input  logic [31:0] Req_Addr,
   input  logic [31:0] Req_Wdata,
   input  logic [3:0]  Req_Strb,
   output logic        Resp_Valid,
   input  logic        Resp_Ready,
   output logic [31:0] Resp_Rdata,
   output logic        Resp_Err
);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        first_q, first_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  strb_q, strb_d;
   logic        err_q, err_d;

   logic        req_bad;
   logic [3:0]  ram_we;
   logic        ram_re;
   logic [31:0] ram_rdata;

   assign req_bad = (addr_q[1:0] != 2'b00)
                  | (|addr_q[31:ADDR_WIDTH+2])
                  | (wr_q & ~strb_legal(strb_q));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      err_d   = err_q;
      ram_we  = 4'b0000;
      ram_re  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Req_Valid) begin
               state_d = ST_ACCESS;
               cnt_d   = 2'(READ_LATENCY - 1);
               first_d = 1'b1;
               wr_d    = Req_Write;
               addr_d  = Req_Addr;
               wdata_d = Req_Wdata;
               strb_d  = Req_Strb;
            end
         end
         ST_ACCESS: begin
            first_d = 1'b0;
            if (first_q && wr_q && !req_bad) begin
               ram_we = strb_q;
            end
            if (cnt_q == 2'd0) begin
               // Stores re-read the word too, so the response carries the merged value
               ram_re  = !req_bad;
               err_d   = req_bad;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_RESP: begin
            if (Resp_Ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         first_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         strb_q  <= 4'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         err_q   <= err_d;
      end
   end

   byte_lane_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk   (Clk),
      .rst   (Rst),
      .addr  (addr_q[ADDR_WIDTH+1:2]),
      .we    (ram_we),
      .wdata (wdata_q),
      .re    (ram_re),
      .rdata (ram_rdata)
   );

   assign Req_Ready  = (state_q == ST_IDLE);
   assign Resp_Valid = (state_q == ST_RESP);
   assign Resp_Err   = err_q;
   assign Resp_Rdata = err_q ? 32'h0 : ram_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

   localparam int LAT = 3;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Req_Valid = 1'b0;
   logic        Req_Ready;
   logic        Req_Write = 1'b0;
   logic [31:0] Req_Addr = 32'h0;
   logic [31:0] Req_Wdata = 32'h0;
   logic [3:0]  Req_Strb = 4'h0;
   logic        Resp_Valid;
   logic        Resp_Ready = 1'b1;
   logic [31:0] Resp_Rdata;
   logic        Resp_Err;

   logic        sw_valid [3];
   logic        sw_ready [3];
   logic [31:0] sw_wdata [3];
   logic        sw_resp_valid [3];
   logic [31:0] sw_rdata [3];
   logic        sw_err [3];

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 Clk = ~Clk;

   data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(LAT)) dut (
      .Clk(Clk), .Rst(Rst),
      .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
      .Req_Addr(Req_Addr), .Req_Wdata(Req_Wdata), .Req_Strb(Req_Strb),
      .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
      .Resp_Rdata(Resp_Rdata), .Resp_Err(Resp_Err)
   );

   for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(gi == 2 ? 4 : gi + 1)) u_sw (
         .Clk(Clk), .Rst(Rst),
         .Req_Valid(sw_valid[gi]), .Req_Ready(sw_ready[gi]), .Req_Write(1'b1),
         .Req_Addr(32'h40), .Req_Wdata(sw_wdata[gi]), .Req_Strb(4'hF),
         .Resp_Valid(sw_resp_valid[gi]), .Resp_Ready(1'b1),
         .Resp_Rdata(sw_rdata[gi]), .Resp_Err(sw_err[gi])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] er, input logic ee);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
      v.exp_rdata = er; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   // Drive one request at a negedge, then wait for and score its response
   task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] er, input logic ee,
                         input string name);
      exp_t e;
      exp_t got;
      int lat;
      @(negedge Clk);
      chk({name, " req_ready"}, 32'(Req_Ready), 32'd1);
      Req_Valid = 1'b1; Req_Write = wr; Req_Addr = addr; Req_Wdata = wdata; Req_Strb = strb;
      e.rdata = er; e.err = ee;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      Req_Valid = 1'b0; Req_Wdata = 32'hX; Req_Addr = 32'hX; Req_Strb = 4'hX;
      lat = 0;
      while (!Resp_Valid && lat < 20) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      chk({name, " latency"}, 32'(lat), 32'(LAT));
      if (sb.size() > 0) begin
         got = sb.pop_front();
         chk({name, " rdata"}, Resp_Rdata, got.rdata);
         chk({name, " err"}, 32'(Resp_Err), 32'(got.err));
      end
      if (Resp_Ready) begin
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] held;
      int a0 [3];
      int a1 [3];
      int v0 [3];
      logic rdy [3];
      int cyc;

      for (int k = 0; k < 3; k++) begin
         sw_valid[k] = 1'b0;
         sw_wdata[k] = 32'hC0DE0000 | 32'(k);
      end

      // Requests during reset must be ignored
      Req_Valid = 1'b1; Req_Write = 1'b0; Req_Addr = 32'h10;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset req_ready", 32'(Req_Ready), 32'd1);
      chk("reset resp_valid", 32'(Resp_Valid), 32'd0);
      chk("reset resp_rdata", Resp_Rdata, 32'h0);
      chk("reset resp_err", 32'(Resp_Err), 32'd0);
      @(negedge Clk);
      Req_Valid = 1'b0;
      Rst = 1'b0;

      add(1, 32'h10,   32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 0);
      add(0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 0);
      add(1, 32'h10,   32'h00AA0000, 4'h4, 32'hDEAABEEF, 0);
      add(1, 32'h10,   32'h12340000, 4'hC, 32'h1234BEEF, 0);
      add(0, 32'h10,   32'h0,        4'h0, 32'h1234BEEF, 0);
      add(1, 32'h0,    32'h11223344, 4'hF, 32'h11223344, 0);
      add(0, 32'h12,   32'h0,        4'h0, 32'h0,        1);
      add(1, 32'h12,   32'hFFFFFFFF, 4'hF, 32'h0,        1);
      add(0, 32'h10,   32'h0,        4'h0, 32'h1234BEEF, 0);
      add(1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1);
      add(0, 32'h1000, 32'h0,        4'h0, 32'h0,        1);
      add(0, 32'h0,    32'h0,        4'h0, 32'h11223344, 0);
      add(1, 32'h10,   32'hFFFFFFFF, 4'h5, 32'h0,        1);
      add(1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0,        1);
      add(0, 32'h10,   32'h0,        4'h0, 32'h1234BEEF, 0);
      add(1, 32'hFFC,  32'hAABBCCDD, 4'hF, 32'hAABBCCDD, 0);
      add(1, 32'hFFC,  32'h00000055, 4'h1, 32'hAABBCC55, 0);
      add(1, 32'hFFC,  32'h66000000, 4'h8, 32'h66BBCC55, 0);
      add(0, 32'hFFC,  32'h0,        4'h5, 32'h66BBCC55, 0);
      add(1, 32'h0,    32'h00007700, 4'h2, 32'h11227744, 0);
      add(1, 32'h0,    32'h99880000, 4'hC, 32'h99887744, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
      end

      // Backpressure: response must hold while Resp_Ready is low
      Resp_Ready = 1'b0;
      do_txn(0, 32'h10, 32'h0, 4'h0, 32'h1234BEEF, 0, "bp");
      held = Resp_Rdata;
      for (int i = 0; i < 5; i++) begin
         @(posedge Clk);
         #1;
         chk("bp resp_valid", 32'(Resp_Valid), 32'd1);
         chk("bp resp_rdata", Resp_Rdata, 32'h1234BEEF);
         chk("bp req_ready", 32'(Req_Ready), 32'd0);
      end
      @(negedge Clk);
      Resp_Ready = 1'b1;
      @(posedge Clk);
      #1;
      chk("bp release req_ready", 32'(Req_Ready), 32'd1);
      chk("bp release resp_valid", 32'(Resp_Valid), 32'd0);
      chk("bp release rdata held", Resp_Rdata, held);

      // Reset after the first ACCESS edge of a store: the word commits
      do_txn(1, 32'h20, 32'h55667788, 4'hF, 32'h55667788, 0, "init20");
      do_txn(1, 32'h24, 32'h01020304, 4'hF, 32'h01020304, 0, "init24");
      @(negedge Clk);
      Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = 32'h20; Req_Wdata = 32'hAAAAAAAA; Req_Strb = 4'hF;
      @(posedge Clk);
      #1;
      Req_Valid = 1'b0;
      @(posedge Clk);
      #1;
      Rst = 1'b1;
      #1;
      chk("rst1 req_ready", 32'(Req_Ready), 32'd1);
      chk("rst1 resp_valid", 32'(Resp_Valid), 32'd0);
      chk("rst1 resp_rdata", Resp_Rdata, 32'h0);
      @(negedge Clk);
      Rst = 1'b0;
      do_txn(0, 32'h20, 32'h0, 4'h0, 32'hAAAAAAAA, 0, "rst1 load");

      // Reset before the first ACCESS edge: nothing is written
      do_txn(0, 32'h2, 32'h0, 4'h0, 32'h0, 1, "pre-rst2 err");
      @(negedge Clk);
      Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = 32'h24; Req_Wdata = 32'hFFFFFFFF; Req_Strb = 4'hF;
      @(posedge Clk);
      #1;
      Req_Valid = 1'b0;
      Rst = 1'b1;
      #1;
      chk("rst2 resp_err", 32'(Resp_Err), 32'd0);
      chk("rst2 req_ready", 32'(Req_Ready), 32'd1);
      @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      do_txn(0, 32'h24, 32'h0, 4'h0, 32'h01020304, 0, "rst2 load");

      // Latency sweep with back-to-back requests and Resp_Ready tied high
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
         sw_valid[k] = 1'b1;
         a0[k] = -1; a1[k] = -1; v0[k] = -1;
      end
      cyc = 0;
      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < 3; k++) rdy[k] = sw_ready[k];
         @(posedge Clk);
         cyc++;
         #1;
         for (int k = 0; k < 3; k++) begin
            if (rdy[k]) begin
               if (a0[k] < 0) a0[k] = cyc;
               else if (a1[k] < 0) a1[k] = cyc;
            end
            if (sw_resp_valid[k] && v0[k] < 0) begin
               v0[k] = cyc;
               chk($sformatf("sweep%0d rdata", k), sw_rdata[k], 32'hC0DE0000 | 32'(k));
            end
         end
         @(negedge Clk);
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("sweep%0d latency", k), 32'(v0[k] - a0[k]), 32'(k == 2 ? 4 : k + 1));
         chk($sformatf("sweep%0d period", k), 32'(a1[k] - a0[k]), 32'((k == 2 ? 4 : k + 1) + 2));
         sw_valid[k] = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
